batcharger_meas_seq: RTL

Measurement sequencer on the supply side of the battery charger controller. It turns the controller's monitor enables (`vmonen`, `imonen`, `tmonen`) into time-multiplexed conversion requests on a shared 8-bit ADC. It returns registered `vbat`, `ibat` and `tbat` codes plus the `vtok` qualifier, which the controller consumes as its measurement inputs.

---
 rtl/batcharger_pkg.sv | 36 +++
 rtl/batcharger_meas_seq_if.sv | 20 ++
 rtl/batcharger_rr_pick.sv | 37 +++
 rtl/batcharger_meas_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/batcharger_pkg.sv
// -----------------------------------------------------------------------------
// batcharger_pkg
// Shared definitions for the battery charger measurement sequencer:
//   - channel encodings on the ADC mux (CH_V, CH_I, CH_T; 2'd3 is unused)
//   - sequencer FSM state type
//   - small helpers for channel enable lookup and round-robin succession
// -----------------------------------------------------------------------------
package batcharger_pkg;

    localparam logic [1:0] CH_V = 2'd0;
    localparam logic [1:0] CH_I = 2'd1;
    localparam logic [1:0] CH_T = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } state_t;

    // mon = {tmonen, imonen, vmonen}
    function automatic logic ch_enabled(input logic [1:0] ch, input logic [2:0] mon);
        case (ch)
            CH_V:    return mon[0];
            CH_I:    return mon[1];
            CH_T:    return mon[2];
            default: return 1'b0;
        endcase
    endfunction

    // V -> I -> T -> V
    function automatic logic [1:0] rr_succ(input logic [1:0] ch);
        return (ch == CH_V) ? CH_I : (ch == CH_I) ? CH_T : CH_V;
    endfunction

endpackage

// File: rtl/batcharger_meas_seq_if.sv
// -----------------------------------------------------------------------------
// batcharger_meas_seq_if
// Shared 8-bit ADC bus between the measurement sequencer and the converter.
//   adc_sel   : mux select (sequencer -> ADC)
//   adc_start : single-cycle conversion start (sequencer -> ADC)
//   adc_done  : single-cycle conversion complete (ADC -> sequencer)
//   adc_data  : result, valid only while adc_done is high (ADC -> sequencer)
// Modports: master = sequencer side, slave = ADC side.
// -----------------------------------------------------------------------------
interface batcharger_meas_seq_if;

    logic [1:0] adc_sel;
    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;

    modport master (output adc_sel, output adc_start, input adc_done, input adc_data);
    modport slave  (input adc_sel, input adc_start, output adc_done, output adc_data);

endinterface

// File: rtl/batcharger_rr_pick.sv
// -----------------------------------------------------------------------------
// batcharger_rr_pick
// Combinational round-robin channel selector. Starting after last_ch, returns
// the first channel (V -> I -> T order) whose monitor enable is high.
//   last_ch in 2 : last serviced channel
//   vmonen, imonen, tmonen in 1 : channel enables
//   next_ch out 2 : chosen channel (CH_V when nothing is enabled)
//   any out 1     : at least one channel is enabled
// -----------------------------------------------------------------------------
module batcharger_rr_pick
    import batcharger_pkg::*;
(
    input  logic [1:0] last_ch,
    input  logic       vmonen,
    input  logic       imonen,
    input  logic       tmonen,
    output logic [1:0] next_ch,
    output logic       any
);

    logic [1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        next_ch = CH_V;
        any     = 1'b0;
        cand    = last_ch;
        for (int k = 0; k < 3; k++) begin
            cand = rr_succ(cand);
            if (!any && ch_enabled(cand, {tmonen, imonen, vmonen})) begin
                next_ch = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/batcharger_meas_seq.sv
// -----------------------------------------------------------------------------
// batcharger_meas_seq
// Time-multiplexes the V/I/T monitor requests onto one shared 8-bit ADC and
// keeps registered codes plus per-channel valid flags.
// Parameters:
//   SETTLE  (1..255) : cycles the mux is held on a channel before adc_start
//   TIMEOUT (1..255) : cycles to wait for adc_done after adc_start
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : sequencer enable
//   vmonen, imonen, tmonen   : channel requests
//   adc (master modport)     : adc_sel / adc_start / adc_done / adc_data
//   vbat, ibat, tbat         : registered codes
//   vtok                     : voltage and temperature samples both valid
//   adc_err                  : sticky conversion timeout flag
// Build option: BATCHARGER_MEAS_AVG_EN -- two conversions per channel visit,
// stored code is their truncated average.
// -----------------------------------------------------------------------------
module batcharger_meas_seq
    import batcharger_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         vmonen,
    input  logic                         imonen,
    input  logic                         tmonen,
    batcharger_meas_seq_if.master        adc,
    output logic [7:0]                   vbat,
    output logic [7:0]                   ibat,
    output logic [7:0]                   tbat,
    output logic                         vtok,
    output logic                         adc_err
);

    state_t     state_q, state_d;
    logic [1:0] chan_q, last_q;
    logic [7:0] settle_q, tmo_q, data_q;
    logic       start_q, drop_q;
    logic [2:0] ok_q;               // indexed by channel code
    logic [1:0] pick_ch;
    logic       pick_any;
    logic [2:0] mon;
    logic       ch_en, done_ok;
    logic       pick_load, start_d, capture, timeout, store;
`ifdef BATCHARGER_MEAS_AVG_EN
    logic       second_q, first_cap;
    logic [7:0] first_q;
    logic [8:0] sum;
`endif

    assign mon       = {tmonen, imonen, vmonen};
    assign ch_en     = ch_enabled(chan_q, mon);
    // A done that coincides with the start pulse belongs to no conversion.
    assign done_ok   = adc.adc_done && !start_q;
    assign adc.adc_sel   = chan_q;
    assign adc.adc_start = start_q;
    assign vtok      = en & ok_q[CH_V] & ok_q[CH_T];

    batcharger_rr_pick u_rr_pick (
        .last_ch (last_q),
        .vmonen  (vmonen),
        .imonen  (imonen),
        .tmonen  (tmonen),
        .next_ch (pick_ch),
        .any     (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pick_load = 1'b0;
        start_d   = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        store     = 1'b0;
`ifdef BATCHARGER_MEAS_AVG_EN
        first_cap = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en && pick_any) begin
                    pick_load = 1'b1;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (settle_q <= 8'd1) begin
                    start_d = 1'b1;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (done_ok) begin
`ifdef BATCHARGER_MEAS_AVG_EN
                    if (!second_q) begin
                        first_cap = 1'b1;
                        start_d   = 1'b1;     // second conversion, no re-settle
                    end else begin
                        capture = 1'b1;
                        state_d = ST_STORE;
                    end
`else
                    capture = 1'b1;
                    state_d = ST_STORE;
`endif
                end else if (tmo_q <= 8'd1) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_STORE: begin
                store   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Disable overrides everything: codes hold, nothing is started or stored.
        if (!en) begin
            state_d   = ST_IDLE;
            pick_load = 1'b0;
            start_d   = 1'b0;
            capture   = 1'b0;
            timeout   = 1'b0;
            store     = 1'b0;
`ifdef BATCHARGER_MEAS_AVG_EN
            first_cap = 1'b0;
`endif
        end
    end

`ifdef BATCHARGER_MEAS_AVG_EN
    assign sum = {1'b0, first_q} + {1'b0, adc.adc_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q   <= CH_V;
            last_q   <= CH_T;     // so the first candidate after reset is V
            settle_q <= 8'd0;
            tmo_q    <= 8'd0;
            data_q   <= 8'h00;
            start_q  <= 1'b0;
            drop_q   <= 1'b0;
            vbat     <= 8'h00;
            ibat     <= 8'h00;
            tbat     <= 8'h00;
            adc_err  <= 1'b0;
            ok_q     <= 3'b000;
`ifdef BATCHARGER_MEAS_AVG_EN
            second_q <= 1'b0;
            first_q  <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            start_q <= start_d;

            if (pick_load) begin
                chan_q   <= pick_ch;
                last_q   <= pick_ch;
                settle_q <= 8'(SETTLE);
            end else if (state_q == ST_SELECT) begin
                settle_q <= settle_q - 8'd1;
            end

            if (start_d)                    tmo_q <= 8'(TIMEOUT);
            else if (state_q == ST_CONVERT) tmo_q <= tmo_q - 8'd1;

            // Remember if the in-flight channel lost its enable at any point.
            if (pick_load)
                drop_q <= 1'b0;
            else if ((state_q inside {ST_SELECT, ST_CONVERT}) && !ch_en)
                drop_q <= 1'b1;

`ifdef BATCHARGER_MEAS_AVG_EN
            if (pick_load) second_q <= 1'b0;
            if (first_cap) begin
                first_q  <= adc.adc_data;
                second_q <= 1'b1;
            end
            if (capture) data_q <= sum[8:1];
`else
            if (capture) data_q <= adc.adc_data;
`endif

            if (store) begin
                case (chan_q)
                    CH_V:    vbat <= data_q;
                    CH_I:    ibat <= data_q;
                    default: tbat <= data_q;
                endcase
            end

            if (timeout) adc_err <= 1'b1;

            // Later assignments win: clears take priority over the set.
            for (int c = 0; c < 3; c++) begin
                if (store && chan_q == 2'(c) && ch_en && !drop_q) ok_q[c] <= 1'b1;
                if (timeout && chan_q == 2'(c))                   ok_q[c] <= 1'b0;
                if (!en || !mon[c])                               ok_q[c] <= 1'b0;
            end
        end
    end

endmodule
